// File: rtl/i2s_pkg.sv
// +-----------------------------------------------------------------------+
// | i2s_pkg : shared defaults and channel constants for the I2S receiver  |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package i2s_pkg;

  localparam int   DEF_WIDTH       = 24;
  localparam int   DEF_SYNC_STAGES = 2;
  localparam logic CH_LEFT         = 1'b0;
  localparam logic CH_RIGHT        = 1'b1;

endpackage

`default_nettype wire

// File: rtl/i2s_sync_edge.sv
// +-----------------------------------------------------------------------+
// | i2s_sync_edge : multi-flop synchronizer with optional rise pulse      |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module i2s_sync_edge #(
  parameter int STAGES  = 2,
  parameter bit EDGE_EN = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int NS = (STAGES < 2) ? 2 : STAGES;

  logic [NS-1:0] chain;

  always_ff @(posedge clk) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[NS-2:0], din};
  end

  assign dout = chain[NS-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic dly;
      always_ff @(posedge clk) begin
        if (!rst_n) dly <= 1'b0;
        else        dly <= dout;
      end
      assign rise = dout & ~dly;
    end else begin : g_no_edge
      assign rise = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/i2s_rx.sv
// +-----------------------------------------------------------------------+
// | i2s_rx : I2S slave receiver, stereo pair out on a valid/ready hold    |
// | Optional: I2S_RX_OVF_COUNT_EN adds the ovf_count output.  rev 1.0     |
// +-----------------------------------------------------------------------+
`default_nettype none

module i2s_rx import i2s_pkg::*; #(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i2s_sck,
  input  logic             i2s_ws,
  input  logic             i2s_sd,
  output logic [WIDTH-1:0] left_data,
  output logic [WIDTH-1:0] right_data,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overflow,
  input  logic             overflow_clr
`ifdef I2S_RX_OVF_COUNT_EN
  ,
  output logic [7:0]       ovf_count
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  logic sck_rise, sck_unused, ws_s, sd_s, ws_rise_unused, sd_rise_unused;

  i2s_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .din(i2s_sck), .dout(sck_unused), .rise(sck_rise));
  i2s_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_ws (
    .clk(clk), .rst_n(rst_n), .din(i2s_ws), .dout(ws_s), .rise(ws_rise_unused));
  i2s_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_sd (
    .clk(clk), .rst_n(rst_n), .din(i2s_sd), .dout(sd_s), .rise(sd_rise_unused));

  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] acc, acc_next, left_pend;
  logic             ws_prev, locked, left_ok;
  logic             ws_edge, commit_left, commit_right, new_pair, load, drop;

  // Bit position WIDTH-1-bit_cnt; once bit_cnt saturates no position matches.
  always_comb begin
    acc_next = acc;
    for (int i = 0; i < WIDTH; i++) begin
      if (int'(bit_cnt) == WIDTH - 1 - i) acc_next[i] = sd_s;
    end
  end

  assign ws_edge      = sck_rise & (ws_s != ws_prev);
  assign commit_left  = ws_edge & locked & (ws_prev == CH_LEFT);
  assign commit_right = ws_edge & locked & (ws_prev == CH_RIGHT);
  assign new_pair     = commit_right & left_ok;
  assign load         = new_pair & (~sample_valid | sample_ready);
  assign drop         = new_pair & sample_valid & ~sample_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ws_prev   <= 1'b0;
      bit_cnt   <= '0;
      acc       <= '0;
      locked    <= 1'b0;
      left_ok   <= 1'b0;
      left_pend <= '0;
    end else if (sck_rise) begin
      ws_prev <= ws_s;
      if (ws_edge) begin
        acc     <= '0;
        bit_cnt <= '0;
        locked  <= 1'b1;
      end else begin
        acc <= acc_next;
        if (bit_cnt < CW'(WIDTH)) bit_cnt <= bit_cnt + CW'(1);
      end
      if (commit_left) begin
        left_pend <= acc_next;
        left_ok   <= 1'b1;
      end
      if (commit_right) left_ok <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      left_data    <= '0;
      right_data   <= '0;
      sample_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (load) begin
        left_data    <= left_pend;
        right_data   <= acc_next;
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

`ifdef I2S_RX_OVF_COUNT_EN
  // A drop coinciding with a clear restarts the count at 1.
  always_ff @(posedge clk) begin
    if (!rst_n)                ovf_count <= 8'd0;
    else if (drop) begin
      if (overflow_clr)        ovf_count <= 8'd1;
      else if (ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
    end else if (overflow_clr) ovf_count <= 8'd0;
  end
`endif

endmodule

`default_nettype wire
